// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between the EX stage (port 0) and the aux unit (port 1).
// Optional ALU_ARB_CTRL_CHECK_EN: illegal ALU ops are forwarded as AND and answered with resp_err=1.
module alu_arbiter #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [WIDTH-1:0]  req_b0,
    input  logic [CTRL_W-1:0] req_ctrl0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [WIDTH-1:0]  req_b1,
    input  logic [CTRL_W-1:0] req_ctrl1,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [WIDTH-1:0]  resp_result,
    output logic              resp_zero,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_lastGrant;
    logic              r_errPending;
    logic [WIDTH-1:0]  r_aluA;
    logic [WIDTH-1:0]  r_aluB;
    logic [CTRL_W-1:0] r_aluCtrl;
    logic              r_respValid;
    logic              r_respId;
    logic [WIDTH-1:0]  r_respResult;
    logic              r_respZero;
    logic              r_respErr;

    logic              w_anyValid;
    logic              w_grant;
    logic              w_illegal;
    logic [WIDTH-1:0]  w_selA;
    logic [WIDTH-1:0]  w_selB;
    logic [CTRL_W-1:0] w_selCtrl;
    logic [CTRL_W-1:0] w_fwdCtrl;

    // On contention the requester not served last wins; otherwise the lone valid requester.
    assign w_anyValid = |req_valid;
    assign w_grant    = (&req_valid) ? ~r_lastGrant : req_valid[1];
    assign w_selA     = w_grant ? req_a1    : req_a0;
    assign w_selB     = w_grant ? req_b1    : req_b0;
    assign w_selCtrl  = w_grant ? req_ctrl1 : req_ctrl0;

`ifdef ALU_ARB_CTRL_CHECK_EN
    logic w_ctrlLegal;

    always_comb begin
        case (w_selCtrl)
            CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(6), CTRL_W'(7): w_ctrlLegal = 1'b1;
            default:                                                    w_ctrlLegal = 1'b0;
        endcase
    end

    assign w_fwdCtrl = w_ctrlLegal ? w_selCtrl : '0;
    assign w_illegal = ~w_ctrlLegal;
`else
    assign w_fwdCtrl = w_selCtrl;
    assign w_illegal = 1'b0;
`endif

    // Gated by reset so nothing is ever accepted on an edge that resets the block.
    always_comb begin
        req_ready = 2'b00;
        if ((r_state == IDLE) && w_anyValid && !reset) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastGrant  <= 1'b1;
            r_errPending <= 1'b0;
            r_aluA       <= '0;
            r_aluB       <= '0;
            r_aluCtrl    <= '0;
            r_respValid  <= 1'b0;
            r_respId     <= 1'b0;
            r_respResult <= '0;
            r_respZero   <= 1'b0;
            r_respErr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_aluA       <= w_selA;
                        r_aluB       <= w_selB;
                        r_aluCtrl    <= w_fwdCtrl;
                        r_errPending <= w_illegal;
                        r_lastGrant  <= w_grant;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // An illegal op reports a zero result regardless of what the ALU produced.
                    r_respValid  <= 1'b1;
                    r_respId     <= r_lastGrant;
                    r_respResult <= r_errPending ? '0 : alu_result;
                    r_respZero   <= r_errPending | alu_zero;
                    r_respErr    <= r_errPending;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_respValid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a       = r_aluA;
    assign alu_b       = r_aluB;
    assign alu_ctrl    = r_aluCtrl;
    assign resp_valid  = r_respValid;
    assign resp_id     = r_respId;
    assign resp_result = r_respResult;
    assign resp_zero   = r_respZero;
    assign resp_err    = r_respErr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus randomized traffic from both requesters.
// A behavioural ALU stands in for the external ALU instance.
module tb_alu_arbiter;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        zero;
        logic        err;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [3:0]  c0 = '0, c1 = '0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] alu_a, alu_b, alu_result, resp_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;

    int   total = 0;
    int   passed = 0;
    exp_t sbq[$];
    bit   mIdle = 1'b1, mPend = 1'b0, mLast = 1'b1, randDone = 1'b0;
    int   mAge = 0;

    assign req_valid = {v1, v0};

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(64), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(a0), .req_b0(b0), .req_ctrl0(c0),
        .req_a1(a1), .req_b1(b1), .req_ctrl1(c1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
    );

    function automatic logic [63:0] aluRef(input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctrl);
        case (ctrl)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        alu_result = aluRef(alu_a, alu_b, alu_ctrl);
        alu_zero   = (alu_result == 64'd0);
    end

    function automatic exp_t predict(input logic id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctrl);
        exp_t e;
        e.id = id; e.a = a; e.b = b; e.ctrl = ctrl; e.err = 1'b0;
`ifdef ALU_ARB_CTRL_CHECK_EN
        if (!(ctrl inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7})) begin
            e.ctrl = 4'h0; e.err = 1'b1; e.res = 64'd0; e.zero = 1'b1;
            return e;
        end
`endif
        e.res  = aluRef(a, b, ctrl);
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        total++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    task automatic applyStimulus(input int id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        if (id == 0) begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
        else         begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
    endtask

    task automatic waitAccepted(input int id, output int cycles);
        bit got = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (req_ready[id]) got = 1'b1;
        end
        if (!got) failNow($sformatf("accept%0d", id));
        @(posedge clk); #1;
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic waitResp(input logic id, input logic [63:0] res, input logic zero, input logic err);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        if (got) begin
            checkOutput("dir_resp_id", resp_id, id);
            checkOutput("dir_resp_result", resp_result, res);
            checkOutput("dir_resp_zero", resp_zero, zero);
            checkOutput("dir_resp_err", resp_err, err);
        end else failNow("dir_resp");
        @(posedge clk); #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_id", resp_id, 0);
        checkOutput("rst_resp_result", resp_result, 0);
        checkOutput("rst_resp_zero", resp_zero, 0);
        checkOutput("rst_resp_err", resp_err, 0);
    endtask

    function automatic logic [3:0] randCtrl();
        case ($urandom_range(0, 6))
            0:       return 4'h0;
            1:       return 4'h1;
            2:       return 4'h2;
            3:       return 4'h6;
            4:       return 4'h7;
            5:       return 4'hF;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic reqLoop(input int id);
        logic [63:0] a, b;
        int cyc;
        repeat (25) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            applyStimulus(id, a, b, randCtrl());
            waitAccepted(id, cyc);
        end
    endtask

    // Transaction-level model: one op in flight, response two cycles after accept, held until taken.
    always @(negedge clk) begin : monitor
        logic [1:0] expRdy;
        logic       g;
        expRdy = 2'b00;
        g      = (v0 && v1) ? ~mLast : v1;
        if (reset) begin
            sbq.delete();
            mIdle = 1'b1; mPend = 1'b0; mLast = 1'b1;
        end else begin
            if (mIdle && (v0 || v1)) expRdy = g ? 2'b10 : 2'b01;
            checkOutput("req_ready", req_ready, expRdy);
            if (mPend) mAge++;
            if (mPend && sbq.size() > 0) begin
                if (mAge == 1) begin
                    checkOutput("alu_a", alu_a, sbq[0].a);
                    checkOutput("alu_b", alu_b, sbq[0].b);
                    checkOutput("alu_ctrl", alu_ctrl, sbq[0].ctrl);
                    checkOutput("resp_valid_early", resp_valid, 0);
                end else begin
                    checkOutput("resp_valid", resp_valid, 1);
                    if (resp_valid) begin
                        checkOutput("resp_id", resp_id, sbq[0].id);
                        checkOutput("resp_result", resp_result, sbq[0].res);
                        checkOutput("resp_zero", resp_zero, sbq[0].zero);
                        checkOutput("resp_err", resp_err, sbq[0].err);
                        if (resp_ready) begin
                            void'(sbq.pop_front());
                            mPend = 1'b0;
                            mIdle = 1'b1;
                        end
                    end
                end
            end else if (!mPend) begin
                checkOutput("resp_spurious", resp_valid, 0);
            end
            if (expRdy != 2'b00) begin
                sbq.push_back(predict(g, g ? a1 : a0, g ? b1 : b0, g ? c1 : c0));
                mPend = 1'b1; mIdle = 1'b0; mAge = 0; mLast = g;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk); #1 reset = 1'b0;

        $display("[TB] single op");
        applyStimulus(0, 64'd2, 64'd2, 4'h2);
        waitAccepted(0, cyc);
        waitResp(1'b0, 64'd4, 1'b0, 1'b0);

        $display("[TB] contention");
        applyStimulus(0, 64'd2, 64'd2, 4'h6);
        applyStimulus(1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'h1);
        waitAccepted(0, cyc);
        waitResp(1'b0, 64'd0, 1'b1, 1'b0);
        waitAccepted(1, cyc);
        waitResp(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        applyStimulus(0, 64'd7, 64'd1, 4'h2);
        applyStimulus(1, 64'd9, 64'd4, 4'h6);
        waitAccepted(0, cyc);
        checkOutput("rr_req0_again", cyc, 1);
        waitResp(1'b0, 64'd8, 1'b0, 1'b0);
        waitAccepted(1, cyc);
        waitResp(1'b1, 64'd5, 1'b0, 1'b0);

        $display("[TB] backpressure");
        resp_ready = 1'b0;
        applyStimulus(0, 64'h10, 64'h3, 4'h6);
        waitAccepted(0, cyc);
        applyStimulus(1, 64'd1, 64'd1, 4'h2);
        waitResp(1'b0, 64'hD, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_valid", resp_valid, 1);
            checkOutput("bp_id", resp_id, 0);
            checkOutput("bp_result", resp_result, 64'hD);
            checkOutput("bp_ready", req_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        waitAccepted(1, cyc);
        checkOutput("bp_idle_next", cyc, 1);
        waitResp(1'b1, 64'd2, 1'b0, 1'b0);

        $display("[TB] reset during EXEC");
        applyStimulus(1, 64'd5, 64'd5, 4'h2);
        waitAccepted(1, cyc);
        reset = 1'b1;
        applyStimulus(0, 64'd3, 64'd4, 4'h0);
        applyStimulus(1, 64'd3, 64'd4, 4'h1);
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk); #1 reset = 1'b0;
        waitAccepted(0, cyc);
        checkOutput("rst_req0_first", cyc, 1);
        waitResp(1'b0, 64'd0, 1'b1, 1'b0);
        waitAccepted(1, cyc);
        waitResp(1'b1, 64'd7, 1'b0, 1'b0);

        $display("[TB] overflow");
        applyStimulus(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2);
        waitAccepted(0, cyc);
        waitResp(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        $display("[TB] illegal ctrl");
        applyStimulus(1, 64'd5, 64'd3, 4'hF);
        waitAccepted(1, cyc);
`ifdef ALU_ARB_CTRL_CHECK_EN
        waitResp(1'b1, 64'd0, 1'b1, 1'b1);
`else
        waitResp(1'b1, 64'd6, 1'b0, 1'b0);
`endif

        $display("[TB] random traffic");
        fork
            begin
                fork
                    reqLoop(0);
                    reqLoop(1);
                join
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1;
                    resp_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        resp_ready = 1'b1;

        for (int i = 0; i < 50 && mPend; i++) @(posedge clk);
        if (mPend) failNow("drain");
        @(negedge clk);
        checkOutput("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
